bp_weight_train_ctrl: RTL and testbench
=======================================

Name: bp_weight_train_ctrl

Overview:
- Sequencer for perceptron weight-table training.
- Accepts resolved-branch records into a small FIFO and decides which ones train.
- For each training record, runs a read-modify-write of one 72-bit weight row: 8 signed 9-bit weights, ±1 saturating update.
- Shares the table's single port with the prediction lookup path, which always has priority.

Parameters:
- ROWS, 228, number of weight-table rows
- NW, 8, weights per row
- WB, 9, bits per signed weight
- IDXW, 8, row index width
- SUMW, 12, signed perceptron sum width
- THETA, 30, training threshold on |sum|
- DEPTH, 4, resolution FIFO depth (power of 2)

Ports:
- fire  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- i_resValid_1  in  1  resolution record valid
- o_resReady_1  out  1  FIFO can accept; equals !full, combinational from the registered count
- i_resIdx_8  in  IDXW  weight row of the resolved branch
- i_resHist_8  in  NW  history bits used at prediction; 1 = taken
- i_resTaken_1  in  1  actual outcome
- i_resSum_12  in  SUMW  signed sum computed at prediction
- i_lookupReq_1  in  1  prediction path owns the table port this cycle
- o_tblRdEn_1  out  1  controller table read strobe
- o_tblRdIdx_8  out  IDXW  read row
- i_tblRdData_72  in  NW*WB  read data, valid exactly 1 cycle after o_tblRdEn_1
- o_tblWrEn_1  out  1  write strobe
- o_tblWrIdx_8  out  IDXW  write row
- o_tblWrData_72  out  NW*WB  updated row
- o_busy_1  out  1  FSM not IDLE, or FIFO not empty
- o_updCnt_16  out  16  completed row writes, saturating at 0xFFFF

Behaviour:
- Reset (rst=1 at a rising edge of fire):
  - FIFO emptied; FSM to IDLE; all strobes 0; o_updCnt_16=0.
  - Any in-flight read data is discarded.
  - No write is issued in the reset cycle, even mid-RMW.
- Enqueue: a record is accepted when i_resValid_1 & o_resReady_1.
  - When full, no enqueue happens even if a dequeue occurs in the same cycle.
  - Upstream holds the record until it is accepted.
- Predicted direction: predTaken = (sum >= 0).
- Training condition: train = (predTaken != taken) | (|sum| <= THETA).
  - |sum| is computed at SUMW+1 bits, so the most negative sum does not overflow.
- FSM states:
  - IDLE:
    - FIFO empty: stay.
    - Head does not train: pop it (1 cycle, no table access), stay in IDLE.
    - Head trains: go to RD.
  - RD:
    - i_lookupReq_1=1: stall, no strobe.
    - Else: o_tblRdEn_1=1 with the head idx, go to WAIT.
  - WAIT:
    - Capture i_tblRdData_72 into a row register.
    - Compute the new row; go to WR.
  - WR:
    - i_lookupReq_1=1: hold the computed row, no strobe.
    - Else: o_tblWrEn_1=1 with the same idx; pop FIFO; increment o_updCnt_16; go to IDLE.
- Update arithmetic, per weight j at bits [j*WB +: WB], two's complement:
  - w += (hist[j]==taken) ? +1 : -1.
  - Saturates at +255 and -256; no wrap.
- Minimum cost of a training record with no lookups: 4 cycles (IDLE, RD, WAIT, WR).
- Records are processed strictly in FIFO order. Back-to-back records on the same row see the prior write, because the RMW is serialized and the next read issues no earlier than the cycle after the write.
- The controller never asserts o_tblRdEn_1 or o_tblWrEn_1 in a cycle where i_lookupReq_1=1.
- Rows are addressed only for idx < ROWS. idx >= ROWS is popped without access, as if train=0.

Decomposition:
- Shared package bp_pkg holds:
  - constants NW, WB, IDXW, SUMW, THETA, ROWS
  - the weight saturation limits
  - a record struct {idx, hist, taken, sum}
- Sub-module bp_weight_row_update: combinational row update (8 parallel saturating ±1 adders).
- FIFO and FSM stay inline.

Test Plan:
- Mispredict: idx=5, hist=0xFF, taken=1, sum=-40; row data all 0 -> one read at idx 5, then write idx 5 with every weight=+1; o_updCnt_16=1; 4 cycles total.
- Saturation: row weights all +255/-256 alternating; taken=1, hist=0x55, sum=-1 -> +255 weights stay +255; -256 weights for hist=0 stay -256.
- Confident correct: sum=+100, taken=1 -> popped in 1 cycle; no rdEn or wrEn; count unchanged.
- Lookup contention: i_lookupReq_1=1 during RD for 3 cycles, then again during WR for 2 cycles -> the read issues on the 4th cycle; the write is delayed 2 cycles with identical data; no strobe overlaps a lookup.
- FIFO full: 5 train records pushed back-to-back while lookups block -> o_resReady_1=0 after 4 accepted; 5th accepted only after the first write; all 5 written in order.
- Reset mid-op: rst asserted in the WAIT cycle -> no write follows; FIFO empty; o_busy_1=0 next cycle; o_updCnt_16=0.

Source files
------------

// File: rtl/bp_weight_train_ctrl_pkg.sv
// bp_pkg: shared constants, record/state types and training decision for the weight-table trainer
package bp_pkg;
  localparam int NW = 8;
  localparam int WB = 9;
  localparam int IDXW = 8;
  localparam int SUMW = 12;
  localparam int THETA = 30;
  localparam int ROWS = 228;
  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [WB-1:0] W_MAX = 9'sh0ff;
  localparam logic signed [WB-1:0] W_MIN = 9'sh100;
  localparam logic signed [SUMW:0] THETA_S = (SUMW+1)'(THETA);
  localparam logic [IDXW-1:0] ROWS_I = IDXW'(ROWS);
  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [NW-1:0] hist;
    logic taken;
    logic signed [SUMW-1:0] sum;
  } rec_t;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_t;
  function automatic logic needs_train(rec_t r);
    logic signed [SUMW:0] s;
    logic signed [SUMW:0] a;
    s = {r.sum[SUMW-1], r.sum};
    a = s[SUMW] ? -s : s;
    return (r.idx < ROWS_I) && (((!s[SUMW]) != r.taken) || (a <= THETA_S));
  endfunction
endpackage

// File: rtl/bp_weight_row_update.sv
// bp_weight_row_update: saturating +/-1 update of every signed weight in a row
module bp_weight_row_update
  import bp_pkg::*;
(
  input  logic [NW*WB-1:0] row,
  input  logic [NW-1:0]    hist,
  input  logic             taken,
  output logic [NW*WB-1:0] upd
);
  for (genvar g = 0; g < NW; g++) begin : g_w
    logic signed [WB-1:0] w;
    assign w = row[g*WB +: WB];
    assign upd[g*WB +: WB] = (hist[g] == taken) ? ((w == W_MAX) ? w : w + WB'(1))
                                                : ((w == W_MIN) ? w : w - WB'(1));
  end
endmodule

// File: rtl/bp_weight_train_ctrl.sv
// bp_weight_train_ctrl: queues resolved branches and runs read-modify-write training of weight rows
module bp_weight_train_ctrl
  import bp_pkg::*;
(
  input  logic               fire,
  input  logic               rst,
  input  logic               i_resValid_1,
  output logic               o_resReady_1,
  input  logic [IDXW-1:0]    i_resIdx_8,
  input  logic [NW-1:0]      i_resHist_8,
  input  logic               i_resTaken_1,
  input  logic [SUMW-1:0]    i_resSum_12,
  input  logic               i_lookupReq_1,
  output logic               o_tblRdEn_1,
  output logic [IDXW-1:0]    o_tblRdIdx_8,
  input  logic [NW*WB-1:0]   i_tblRdData_72,
  output logic               o_tblWrEn_1,
  output logic [IDXW-1:0]    o_tblWrIdx_8,
  output logic [NW*WB-1:0]   o_tblWrData_72,
  output logic               o_busy_1,
  output logic [15:0]        o_updCnt_16
);
  rec_t mem [DEPTH];
  rec_t head;
  rec_t in_rec;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0] cnt;
  state_t state;
  state_t nxt;
  logic [NW*WB-1:0] row_q;
  logic [NW*WB-1:0] row_upd;
  logic push;
  logic pop;
  logic rd_en;
  logic wr_en;
  logic head_train;
  assign in_rec = '{idx: i_resIdx_8, hist: i_resHist_8, taken: i_resTaken_1, sum: i_resSum_12};
  assign head = mem[rd_ptr];
  assign head_train = needs_train(head);
  assign o_resReady_1 = cnt != (AW+1)'(DEPTH);
  assign push = i_resValid_1 && o_resReady_1;
  assign o_tblRdEn_1 = rd_en;
  assign o_tblWrEn_1 = wr_en;
  assign o_tblRdIdx_8 = head.idx;
  assign o_tblWrIdx_8 = head.idx;
  assign o_tblWrData_72 = row_q;
  assign o_busy_1 = (state != S_IDLE) || (cnt != '0);
  bp_weight_row_update u_upd (
    .row   (i_tblRdData_72),
    .hist  (head.hist),
    .taken (head.taken),
    .upd   (row_upd)
  );
  always_ff @(posedge fire) begin
    if (push) mem[wr_ptr] <= in_rec;
  end
  always_ff @(posedge fire) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge fire) begin
    if (rst) begin
      state <= S_IDLE;
      o_updCnt_16 <= '0;
    end else begin
      state <= nxt;
      o_updCnt_16 <= (wr_en && o_updCnt_16 != 16'hffff) ? o_updCnt_16 + 16'd1 : o_updCnt_16;
    end
  end
  always_ff @(posedge fire) begin
    if (state == S_WAIT) row_q <= row_upd;
  end
  always_comb begin
    nxt = state;
    rd_en = 1'b0;
    wr_en = 1'b0;
    pop = 1'b0;
    case (state)
      S_IDLE: begin
        nxt = (cnt != '0 && head_train) ? S_RD : S_IDLE;
        pop = (cnt != '0) && !head_train;
      end
      S_RD: begin
        rd_en = !i_lookupReq_1 && !rst;
        nxt = i_lookupReq_1 ? S_RD : S_WAIT;
      end
      S_WAIT: nxt = S_WR;
      S_WR: begin
        wr_en = !i_lookupReq_1 && !rst;
        pop = wr_en;
        nxt = i_lookupReq_1 ? S_WR : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_bp_weight_train_ctrl.sv
// tb_bp_weight_train_ctrl: scoreboard bench with a table model and a high-level training reference
module tb_bp_weight_train_ctrl;
  logic fire = 1'b0;
  logic rst;
  logic valid;
  logic ready;
  logic [7:0] idx_in;
  logic [7:0] hist_in;
  logic taken_in;
  logic [11:0] sum_in;
  logic lookup;
  logic rd_en;
  logic [7:0] rd_idx;
  logic [71:0] rd_data;
  logic wr_en;
  logic [7:0] wr_idx;
  logic [71:0] wr_data;
  logic busy;
  logic [15:0] upd_cnt;
  logic pre_en;
  logic [7:0] pre_idx;
  logic [71:0] pre_val;
  logic [71:0] tbl [256];
  logic [71:0] model_tbl [256];
  typedef struct {
    int idx;
    logic [71:0] row;
  } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int n_rd = 0;
  int n_wr = 0;
  int exp_trains = 0;
  bit done = 0;

  always #5 fire = ~fire;

  bp_weight_train_ctrl dut (
    .fire           (fire),
    .rst            (rst),
    .i_resValid_1   (valid),
    .o_resReady_1   (ready),
    .i_resIdx_8     (idx_in),
    .i_resHist_8    (hist_in),
    .i_resTaken_1   (taken_in),
    .i_resSum_12    (sum_in),
    .i_lookupReq_1  (lookup),
    .o_tblRdEn_1    (rd_en),
    .o_tblRdIdx_8   (rd_idx),
    .i_tblRdData_72 (rd_data),
    .o_tblWrEn_1    (wr_en),
    .o_tblWrIdx_8   (wr_idx),
    .o_tblWrData_72 (wr_data),
    .o_busy_1       (busy),
    .o_updCnt_16    (upd_cnt)
  );

  task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] model_upd(logic [71:0] r, logic [7:0] h, logic t);
    for (int j = 0; j < 8; j++) begin
      int w;
      w = $signed(r[j*9 +: 9]);
      w = w + ((h[j] == t) ? 1 : -1);
      if (w > 255) w = 255;
      if (w < -256) w = -256;
      r[j*9 +: 9] = 9'(w);
    end
    return r;
  endfunction

  function automatic bit model_train(int idx, int s, bit t);
    int a;
    a = (s < 0) ? -s : s;
    if (idx >= 228) return 1'b0;
    return ((s >= 0) != t) || (a <= 30);
  endfunction

  function automatic logic [71:0] rand_row();
    logic [71:0] r;
    for (int j = 0; j < 8; j++) begin
      int c;
      c = int'($urandom_range(0, 4));
      r[j*9 +: 9] = (c == 0) ? 9'h0ff : (c == 1) ? 9'h0fe : (c == 2) ? 9'h100 :
                    (c == 3) ? 9'h101 : 9'($urandom);
    end
    return r;
  endfunction

  always @(posedge fire) begin
    rd_data <= rd_en ? tbl[rd_idx] : 72'({$urandom(), $urandom(), $urandom()});
    if (wr_en) tbl[wr_idx] <= wr_data;
    if (pre_en) tbl[pre_idx] <= pre_val;
  end

  always @(negedge fire) begin
    exp_t e;
    logic [71:0] nr;
    int s;
    if (rst) begin
      chk("rst_no_wr", 72'(wr_en), 72'(0));
      q.delete();
      model_tbl = tbl;
      n_rd = 0;
      n_wr = 0;
      exp_trains = 0;
    end else begin
      if (pre_en) model_tbl[pre_idx] = pre_val;
      if (rd_en || wr_en) chk("strobe_vs_lookup", 72'(lookup), 72'(0));
      if (rd_en) begin
        n_rd++;
        chk("rd_idx_in_range", 72'(rd_idx < 8'd228), 72'(1));
      end
      if (wr_en) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: idx %0d data %0h, no write expected", wr_idx, wr_data);
        end else begin
          e = q.pop_front();
          chk("wr_idx", 72'(wr_idx), 72'(e.idx));
          chk("wr_data", wr_data, e.row);
          chk("upd_cnt_at_wr", 72'(upd_cnt), 72'(n_wr));
        end
        n_wr++;
      end
      if (valid && ready) begin
        s = $signed(sum_in);
        if (model_train(int'(idx_in), s, taken_in)) begin
          nr = model_upd(model_tbl[idx_in], hist_in, taken_in);
          model_tbl[idx_in] = nr;
          e.idx = int'(idx_in);
          e.row = nr;
          q.push_back(e);
          exp_trains++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge fire);
    #1;
  endtask

  task automatic send(int idx, logic [7:0] h, bit t, int s);
    bit acc;
    int k;
    acc = 0;
    k = 0;
    valid = 1'b1;
    idx_in = 8'(idx);
    hist_in = h;
    taken_in = t;
    sum_in = 12'(s);
    while (!acc && k < 300) begin
      @(negedge fire);
      acc = ready;
      tick();
      k++;
    end
    valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: record idx %0d never accepted", idx);
    end
  endtask

  task automatic preload(int idx, logic [71:0] v);
    pre_en = 1'b1;
    pre_idx = 8'(idx);
    pre_val = v;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic run_obs(output int rdk, output int wrk, output logic [7:0] ri, output logic [71:0] wd);
    rdk = -1;
    wrk = -1;
    ri = '0;
    wd = '0;
    for (int k = 1; k <= 30 && wrk < 0; k++) begin
      tick();
      if (rd_en && rdk < 0) begin
        rdk = k;
        ri = rd_idx;
      end
      if (wr_en) begin
        wrk = k;
        wd = wr_data;
      end
    end
    if (wrk < 0) begin
      checks++;
      errors++;
      $display("FAIL obs_timeout: no write within 30 cycles");
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 3000) begin
      tick();
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still 1");
    end
  endtask

  initial begin
    int rdk;
    int wrk;
    int base;
    int strobes;
    logic [7:0] ri;
    logic [71:0] wd;
    logic [71:0] sat;
    logic [71:0] ones;
    logic [15:0] cnt0;
    rst = 1'b1;
    valid = 1'b0;
    lookup = 1'b0;
    pre_en = 1'b0;
    pre_idx = '0;
    pre_val = '0;
    idx_in = '0;
    hist_in = '0;
    taken_in = 1'b0;
    sum_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("reset_ready", 72'(ready), 72'(1));
    chk("reset_busy", 72'(busy), 72'(0));
    chk("reset_updcnt", 72'(upd_cnt), 72'(0));
    chk("reset_rden", 72'(rd_en), 72'(0));
    chk("reset_wren", 72'(wr_en), 72'(0));
    for (int i = 0; i < 256; i++) preload(i, rand_row());

    preload(5, 72'(0));
    send(5, 8'hff, 1'b1, -40);
    run_obs(rdk, wrk, ri, wd);
    for (int j = 0; j < 8; j++) ones[j*9 +: 9] = 9'h001;
    chk("mispredict_rd_cycle", 72'(rdk), 72'(1));
    chk("mispredict_rd_idx", 72'(ri), 72'(5));
    chk("mispredict_wr_cycle", 72'(wrk), 72'(3));
    chk("mispredict_wr_data", wd, ones);
    tick();
    chk("mispredict_updcnt", 72'(upd_cnt), 72'(1));
    chk("mispredict_idle", 72'(busy), 72'(0));

    for (int j = 0; j < 8; j++) sat[j*9 +: 9] = (j % 2 == 0) ? 9'h0ff : 9'h100;
    preload(9, sat);
    send(9, 8'h55, 1'b1, -1);
    run_obs(rdk, wrk, ri, wd);
    chk("saturate_wr_data", wd, sat);
    chk("saturate_wr_cycle", 72'(wrk), 72'(3));
    tick();

    cnt0 = upd_cnt;
    send(7, 8'h0f, 1'b1, 100);
    chk("confident_busy_head", 72'(busy), 72'(1));
    tick();
    chk("confident_popped", 72'(busy), 72'(0));
    strobes = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      strobes += int'(rd_en) + int'(wr_en);
    end
    chk("confident_no_strobe", 72'(strobes), 72'(0));
    chk("confident_updcnt", 72'(upd_cnt), 72'(cnt0));

    send(11, 8'ha5, 1'b0, 3);
    tick();
    lookup = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("contend_rd_stall", 72'(rd_en), 72'(0));
      if (k < 2) tick();
    end
    tick();
    lookup = 1'b0;
    #1;
    chk("contend_rd_4th", 72'(rd_en), 72'(1));
    tick();
    chk("contend_wait_no_wr", 72'(wr_en), 72'(0));
    tick();
    lookup = 1'b1;
    #1;
    chk("contend_wr_stall0", 72'(wr_en), 72'(0));
    tick();
    chk("contend_wr_stall1", 72'(wr_en), 72'(0));
    tick();
    lookup = 1'b0;
    #1;
    chk("contend_wr_go", 72'(wr_en), 72'(1));
    tick();

    base = n_wr;
    lookup = 1'b1;
    send(20, 8'h3c, 1'b1, 0);
    send(21, 8'hc3, 1'b0, 5);
    send(22, 8'hf0, 1'b1, -7);
    send(20, 8'h0f, 1'b0, 30);
    chk("full_not_ready", 72'(ready), 72'(0));
    fork
      begin
        send(21, 8'h99, 1'b1, -31);
        chk("full_5th_after_first_wr", 72'(n_wr - base), 72'(1));
      end
      begin
        repeat (6) tick();
        lookup = 1'b0;
      end
    join
    wait_idle();
    chk("full_all_written", 72'(n_wr - base), 72'(5));

    for (int st = 2; st <= 3; st++) begin
      send(30, 8'h12, 1'b1, 0);
      repeat (st) tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_no_wr", 72'(wr_en), 72'(0));
      tick();
      rst = 1'b0;
      #1;
      chk("rst_mid_busy", 72'(busy), 72'(0));
      chk("rst_mid_ready", 72'(ready), 72'(1));
      chk("rst_mid_updcnt", 72'(upd_cnt), 72'(0));
      strobes = 0;
      for (int k = 0; k < 5; k++) begin
        tick();
        strobes += int'(rd_en) + int'(wr_en);
      end
      chk("rst_mid_quiet", 72'(strobes), 72'(0));
    end

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int ix;
          int s;
          ix = ($urandom_range(0, 9) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 7));
          s = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 100)) - 50;
          send(ix, 8'($urandom), 1'($urandom), s);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
        end
        done = 1;
      end
      begin
        while (!done) begin
          lookup = ($urandom_range(0, 9) < 3);
          tick();
        end
        lookup = 1'b0;
      end
    join
    wait_idle();
    tick();
    chk("final_queue_empty", 72'(q.size()), 72'(0));
    chk("final_writes", 72'(n_wr), 72'(exp_trains));
    chk("final_reads", 72'(n_rd), 72'(exp_trains));
    chk("final_updcnt", 72'(upd_cnt), 72'(exp_trains));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
